// File: rtl/acc_stack_pkg.sv
// Shared SFR operation encoding for the accumulator/stack block.
// The control unit and the bench both import these codes.
package acc_stack_pkg;

    localparam int ACC_OP_LEN = 4;

    typedef logic [ACC_OP_LEN-1:0] acc_op_t;

    localparam acc_op_t ACC_OP_NOP     = 4'd0;
    localparam acc_op_t ACC_OP_WR_WORD = 4'd1;
    localparam acc_op_t ACC_OP_WR_BIT  = 4'd2;
    localparam acc_op_t ACC_OP_CLR     = 4'd3;
    localparam acc_op_t ACC_OP_CPL     = 4'd4;
    localparam acc_op_t ACC_OP_INC     = 4'd5;
    localparam acc_op_t ACC_OP_DEC     = 4'd6;
    localparam acc_op_t ACC_OP_RL      = 4'd7;
    localparam acc_op_t ACC_OP_RR      = 4'd8;
    localparam acc_op_t ACC_OP_SWAP    = 4'd9;
    localparam acc_op_t ACC_OP_PUSH    = 4'd10;
    localparam acc_op_t ACC_OP_POP     = 4'd11;
    localparam acc_op_t ACC_OP_CLR_ERR = 4'd12;

endpackage

// File: rtl/acc_lifo.sv
// Register-array LIFO used to save/restore the accumulator.
// Push is ignored when full and pop when empty; the caller raises the error flags.
module acc_lifo
    import acc_stack_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int SP_W  = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    logic [SP_W-1:0]  sp_q, sp_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    assign o_full  = (sp_q == SP_W'(DEPTH));
    assign o_empty = (sp_q == '0);

    always_comb begin
        // NOTE: assign a default before any branch so no path leaves sp_d unassigned (no latch).
        sp_d = sp_q;
        if (i_push && !o_full) begin
            sp_d = sp_q + SP_W'(1);
        end else if (i_pop && !o_empty) begin
            sp_d = sp_q - SP_W'(1);
        end
    end

    // Top-of-stack entry; an equality mux avoids indexing with the wider sp.
    always_comb begin
        o_rdata = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sp_q == SP_W'(i + 1)) begin
                o_rdata = mem_q[i];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
        if (!i_rst) begin
            sp_q <= '0;
        end else begin
            sp_q <= sp_d;
        end
    end

    // NOTE: storage is deliberately not reset; entries above sp are never read.
    always_ff @(posedge i_clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (i_push && !o_full && sp_q == SP_W'(i)) begin
                mem_q[i] <= i_wdata;
            end
        end
    end

endmodule

// File: rtl/acc_stack.sv
// Accumulator SFR with byte/bit writes, single-cycle ALU updates and a LIFO
// for context save/restore; sticky overflow/underflow flags.
module acc_stack
    import acc_stack_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [WIDTH-1:0]      i_data,
    input  logic [ACC_OP_LEN-1:0] i_op,
    output logic [WIDTH-1:0]      o_acc,
    output logic                  o_parity,
    output logic                  o_zero,
    output logic                  o_full,
    output logic                  o_empty,
    output logic                  o_ovf,
    output logic                  o_unf
);

    localparam int IDX_W = $clog2(WIDTH);
    localparam int SP_W  = $clog2(DEPTH + 1);
    localparam int HALF  = WIDTH / 2;

    logic [WIDTH-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic [WIDTH-1:0] lifo_rdata;
    logic             lifo_full, lifo_empty;
    logic             push_req, pop_req;
    logic [IDX_W-1:0] bit_idx;

    assign push_req = (i_op == ACC_OP_PUSH);
    assign pop_req  = (i_op == ACC_OP_POP);
    assign bit_idx  = i_data[IDX_W:1];

    acc_lifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .SP_W  (SP_W)
    ) u_lifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (push_req),
        .i_pop   (pop_req),
        .i_wdata (acc_q),
        .o_rdata (lifo_rdata),
        .o_full  (lifo_full),
        .o_empty (lifo_empty)
    );

    always_comb begin
        acc_d = acc_q;
        ovf_d = ovf_q;
        unf_d = unf_q;
        case (i_op)
            ACC_OP_WR_WORD: acc_d = i_data;
            ACC_OP_WR_BIT: begin
                // Out-of-range indices (non-power-of-2 WIDTH) match no bit and leave acc alone.
                for (int b = 0; b < WIDTH; b++) begin
                    if (bit_idx == IDX_W'(b)) acc_d[b] = i_data[0];
                end
            end
            ACC_OP_CLR:  acc_d = '0;
            ACC_OP_CPL:  acc_d = ~acc_q;
            ACC_OP_INC:  acc_d = acc_q + WIDTH'(1);
            ACC_OP_DEC:  acc_d = acc_q - WIDTH'(1);
            ACC_OP_RL:   acc_d = {acc_q[WIDTH-2:0], acc_q[WIDTH-1]};
            ACC_OP_RR:   acc_d = {acc_q[0], acc_q[WIDTH-1:1]};
            ACC_OP_SWAP: acc_d = {acc_q[HALF-1:0], acc_q[WIDTH-1:HALF]};
            ACC_OP_PUSH: if (lifo_full) ovf_d = 1'b1;
            ACC_OP_POP: begin
                if (lifo_empty) unf_d = 1'b1;
                else            acc_d = lifo_rdata;
            end
            ACC_OP_CLR_ERR: begin
                ovf_d = 1'b0;
                unf_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign o_acc    = acc_q;
    assign o_parity = ^acc_q;
    assign o_zero   = (acc_q == '0);
    assign o_full   = lifo_full;
    assign o_empty  = lifo_empty;
    assign o_ovf    = ovf_q;
    assign o_unf    = unf_q;

endmodule

// File: tb/tb_acc_stack.sv
// Scoreboard bench for acc_stack (WIDTH=8, DEPTH=4): stimulus pushes model
// expectations tagged with the target cycle; a monitor pops and compares.
module tb_acc_stack;
    import acc_stack_pkg::*;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] data;
    acc_op_t          op;
    logic [WIDTH-1:0] o_acc;
    logic             o_parity, o_zero, o_full, o_empty, o_ovf, o_unf;

    acc_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .i_clk    (clk),
        .i_rst    (rst_n),
        .i_data   (data),
        .i_op     (op),
        .o_acc    (o_acc),
        .o_parity (o_parity),
        .o_zero   (o_zero),
        .o_full   (o_full),
        .o_empty  (o_empty),
        .o_ovf    (o_ovf),
        .o_unf    (o_unf)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [7:0] acc;
        logic [5:0] flags; // {parity, zero, full, empty, ovf, unf}
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    // Behavioural reference: integer accumulator, queue as the stack.
    int   m_acc = 0;
    int   m_stack[$];
    bit   m_ovf = 0;
    bit   m_unf = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, req);
        end
    endtask

    task automatic model(input bit rst, input acc_op_t o, input int d);
        int idx;
        if (rst) begin
            m_acc = 0;
            m_stack.delete();
            m_ovf = 0;
            m_unf = 0;
            return;
        end
        case (o)
            ACC_OP_WR_WORD: m_acc = d;
            ACC_OP_WR_BIT: begin
                idx = (d / 2) % 8;
                if (d % 2 == 1) m_acc = m_acc | (1 << idx);
                else            m_acc = m_acc & (255 - (1 << idx));
            end
            ACC_OP_CLR:  m_acc = 0;
            ACC_OP_CPL:  m_acc = 255 - m_acc;
            ACC_OP_INC:  m_acc = (m_acc + 1) % 256;
            ACC_OP_DEC:  m_acc = (m_acc + 255) % 256;
            ACC_OP_RL:   m_acc = ((m_acc * 2) % 256) + (m_acc / 128);
            ACC_OP_RR:   m_acc = (m_acc / 2) + (m_acc % 2) * 128;
            ACC_OP_SWAP: m_acc = ((m_acc % 16) * 16) + (m_acc / 16);
            ACC_OP_PUSH: begin
                if (m_stack.size() == DEPTH) m_ovf = 1;
                else                         m_stack.push_back(m_acc);
            end
            ACC_OP_POP: begin
                if (m_stack.size() == 0) m_unf = 1;
                else                     m_acc = m_stack.pop_back();
            end
            ACC_OP_CLR_ERR: begin
                m_ovf = 0;
                m_unf = 0;
            end
            default: ;
        endcase
    endtask

    // Drive one cycle of stimulus and record what the outputs must show after the edge.
    task automatic step(input bit rst, input acc_op_t o, input int d);
        exp_t e;
        rst_n = !rst;
        op    = o;
        data  = 8'(d);
        model(rst, o, d);
        e.cyc   = cyc + 1;
        e.acc   = 8'(m_acc);
        e.flags = {1'($countones(m_acc) % 2), m_acc == 0, m_stack.size() == DEPTH,
                   m_stack.size() == 0, m_ovf, m_unf};
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                e = exp_q.pop_front();
                check("cycle_tag", 32'(cyc), 32'(e.cyc));
                check("acc", 32'(o_acc), 32'(e.acc));
                check("flags{par,zero,full,empty,ovf,unf}",
                      32'({o_parity, o_zero, o_full, o_empty, o_ovf, o_unf}), 32'(e.flags));
            end
        end
    end

    initial begin : stimulus
        int r;
        int budget;
        // Reset overrides a write
        step(1, ACC_OP_WR_WORD, 8'hA5);
        step(1, ACC_OP_WR_WORD, 8'hA5);
        step(0, ACC_OP_NOP, 0);
        // Bit writes
        step(0, ACC_OP_WR_WORD, 8'h00);
        step(0, ACC_OP_WR_BIT, 8'h0F);
        step(0, ACC_OP_WR_BIT, 8'h0E);
        // Arithmetic wrap
        step(0, ACC_OP_WR_WORD, 8'hFF);
        step(0, ACC_OP_INC, 0);
        step(0, ACC_OP_DEC, 0);
        // Rotates, swap, complement
        step(0, ACC_OP_WR_WORD, 8'h81);
        step(0, ACC_OP_RL, 0);
        step(0, ACC_OP_RR, 0);
        step(0, ACC_OP_WR_WORD, 8'h3C);
        step(0, ACC_OP_SWAP, 0);
        step(0, ACC_OP_CPL, 0);
        // Fill, overflow, drain, underflow, clear errors
        for (int i = 1; i <= 4; i++) begin
            step(0, ACC_OP_WR_WORD, i * 8'h11);
            step(0, ACC_OP_PUSH, 0);
        end
        step(0, ACC_OP_PUSH, 0);
        for (int i = 0; i < 5; i++) step(0, ACC_OP_POP, 0);
        step(0, ACC_OP_CLR_ERR, 0);
        // Reset coincident with a POP mid-stack
        step(0, ACC_OP_WR_WORD, 8'h55);
        step(0, ACC_OP_PUSH, 0);
        step(0, ACC_OP_WR_WORD, 8'h66);
        step(0, ACC_OP_PUSH, 0);
        step(1, ACC_OP_POP, 0);
        step(0, ACC_OP_POP, 0);
        step(0, ACC_OP_CLR_ERR, 0);
        // Random traffic, biased toward stack ops, with occasional resets
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 19);
            if (r >= 16) r = (r % 2 == 0) ? int'(ACC_OP_PUSH) : int'(ACC_OP_POP);
            step($urandom_range(0, 49) == 0, acc_op_t'(r), $urandom_range(0, 255));
        end
        step(0, ACC_OP_NOP, 0);
        budget = 10;
        while (exp_q.size() > 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/acc_stack.md
Name: acc_stack

Overview:
- Parametrised successor to the 8051 SoC accumulator SFR.
- Holds a WIDTH-bit accumulator and supports the original byte-write and bit-write operations.
- Adds single-cycle ALU-style updates (inc/dec/rotate/swap/complement/clear).
- Adds a DEPTH-entry LIFO for context save/restore of the accumulator.
- Sits in the SFR block and is driven by the control unit's decoded SFR operation code.

Parameters:
- WIDTH, 8: accumulator width in bits. Must be even and ≥4.
- DEPTH, 4: LIFO entries. Must be ≥1.
- IDX_W, $clog2(WIDTH): bit-index width for bit writes. Derived; do not override.
- SP_W, $clog2(DEPTH+1): stack-pointer width. Derived.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst  in  1  synchronous reset, active-low (0 = reset, sampled on rising i_clk).
- i_data  in  WIDTH  operand. For ACC_WR_WORD it is the new value. For ACC_WR_BIT, i_data[0] is the bit value and i_data[IDX_W:1] is the bit index.
- i_op  in  `ACC_OP_LEN (4)  encoded operation, one per cycle.
- o_acc  out  WIDTH  accumulator.
- o_parity  out  1  XOR of all o_acc bits.
- o_zero  out  1  high when o_acc == 0.
- o_full  out  1  high when sp == DEPTH.
- o_empty  out  1  high when sp == 0.
- o_ovf  out  1  sticky: a PUSH was attempted while full.
- o_unf  out  1  sticky: a POP was attempted while empty.

Behaviour:
- Reset (i_rst == 0 at clock edge):
  - acc=0, sp=0, ovf=0, unf=0.
  - Stack contents are don't-care.
  - Resulting outputs: o_acc=0, o_parity=0, o_zero=1, o_empty=1, o_full=0.
  - Reset overrides any i_op in the same cycle, including mid-sequence PUSH/POP.
- Timing:
  - Every operation completes in one cycle; the result is visible on outputs after the edge.
  - o_parity, o_zero, o_full and o_empty are combinational from registered state (no extra latency).
- Op encoding (`ACC_OP_*`):
  - 0 NOP: hold all state.
  - 1 WR_WORD: acc <= i_data.
  - 2 WR_BIT: acc[idx] <= i_data[0], other bits unchanged. If idx ≥ WIDTH (non-power-of-2 WIDTH), no change.
  - 3 CLR: acc <= 0.
  - 4 CPL: acc <= ~acc.
  - 5 INC: acc <= acc+1, modulo 2^WIDTH (all-ones wraps to 0).
  - 6 DEC: acc <= acc-1, modulo 2^WIDTH (0 wraps to all-ones).
  - 7 RL: acc <= {acc[WIDTH-2:0], acc[WIDTH-1]}.
  - 8 RR: acc <= {acc[0], acc[WIDTH-1:1]}.
  - 9 SWAP: exchange upper and lower WIDTH/2 halves.
  - 10 PUSH:
    - If not full: stack[sp] <= acc, sp <= sp+1, acc unchanged.
    - If full: no state change except ovf <= 1.
  - 11 POP:
    - If not empty: acc <= stack[sp-1], sp <= sp-1.
    - If empty: acc unchanged, unf <= 1.
  - 12 CLR_ERR: ovf <= 0, unf <= 0. acc and sp unchanged.
  - 13–15: reserved, behave as NOP.
- Sticky flags are cleared only by reset or CLR_ERR. A CLR_ERR is never combined with another op (one op per cycle).
- Back-to-back PUSH then POP returns the pushed value. PUSH×DEPTH then POP×DEPTH returns the values in reverse order.
- No read-before-write hazard: a POP in the cycle after a PUSH reads the entry just written.
- The stack is implemented as a register array (no RAM inference needed). Unused entries retain stale data.

Decomposition:
- Defines.v (shared package) gains:
  - `ACC_OP_LEN (4) and `ACC_OP_NOP … `ACC_OP_CLR_ERR codes, so the control unit and bench share the encoding.
- One natural sub-module, acc_lifo: WIDTH×DEPTH storage plus sp, full/empty, push/pop enables and a read-data port. The top level contains the op decode, accumulator datapath and sticky flags.

Test Plan:
- Reset: hold i_rst=0 for 2 cycles while i_op=WR_WORD, i_data=8'hA5 -> o_acc=0, o_zero=1, o_empty=1, o_ovf=0, o_unf=0. After release with NOP, o_acc stays 0.
- Bit ops: WR_WORD 8'h00, then WR_BIT i_data=8'h0F (idx7, val1) -> o_acc=8'h80, o_parity=1. Then WR_BIT i_data=8'h0E -> 8'h00.
- Arithmetic wrap: WR_WORD 8'hFF, INC -> 8'h00 with o_zero=1. DEC -> 8'hFF.
- Shifts: start from 8'h81. RL -> 8'h03. RR -> 8'h81. SWAP on 8'h3C -> 8'hC3. CPL -> 8'h3C.
- Stack order: WIDTH=8, DEPTH=4. Push 8'h11, 8'h22, 8'h33, 8'h44 -> o_full=1. A fifth PUSH -> o_ovf=1 and contents unchanged. Four POPs yield 44, 33, 22, 11 with o_empty=1. A fifth POP -> o_unf=1 and acc stays 8'h11. CLR_ERR clears both flags.
- Reset mid-stack: push 2 entries, assert i_rst=0 coincident with a POP -> sp=0, o_acc=0, o_empty=1. A following POP sets o_unf=1.
